srl_fifo_reader: RTL and testbench
==================================

Name: srl_fifo_reader

Overview:
- Synchronous FIFO built on 32-deep addressable shift-register storage, one shift column per data bit.
- The write side shifts each new word into tap 0.
- This block owns the read end: it keeps an occupancy counter, drives the tap address of the oldest word, pops words and produces the status flags.
- Sits between the UART/peripheral byte streams and the processor port logic, which polls its status and strobes reads.

Parameters:
- WIDTH, 8, data word width in bits.
- HALF_LEVEL, 16, occupancy at or above which HALF_FULL asserts (1..32).

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous active-low reset
- DATA_IN  input  WIDTH  word to push
- WRITE  input  1  push strobe, one word per cycle while high
- READ  input  1  pop strobe, one word per cycle while high
- DATA_OUT  output  WIDTH  oldest stored word
- DATA_PRESENT  output  1  occupancy non-zero
- HALF_FULL  output  1  occupancy >= HALF_LEVEL
- FULL  output  1  occupancy == 32
- COUNT  output  6  occupancy 0..32
- OVERFLOW  output  1  one-cycle pulse: push dropped
- UNDERFLOW  output  1  one-cycle pulse: pop of empty FIFO

Behaviour:
- Storage:
  - WIDTH x 32-bit shift columns. On an accepted push, every column shifts up by one and DATA_IN enters tap 0.
  - Storage is not reset. Simulation initialises it to zero.
- Read address:
  - ptr[4:0] = COUNT-1 when COUNT>0, else 0.
  - DATA_OUT = storage tap [ptr], combinational from ptr and storage (zero-cycle read latency).
  - DATA_OUT is defined only while DATA_PRESENT=1.
- Reset (RESET_N low, asynchronous):
  - COUNT=0, DATA_PRESENT=0, HALF_FULL=0, FULL=0, OVERFLOW=0, UNDERFLOW=0.
  - Reset mid-stream discards all queued words logically; storage contents are left as-is.
- Each rising edge, with c = COUNT:
  - WRITE only, c<32: shift, COUNT=c+1.
  - WRITE only, c==32: no shift, COUNT unchanged, OVERFLOW=1 next cycle.
  - READ only, c>0: COUNT=c-1, no shift.
  - READ only, c==0: no change, UNDERFLOW=1 next cycle.
  - WRITE and READ, 0<c<=32: shift and pop together, COUNT unchanged, ptr unchanged.
    - The shift moves the next-oldest word into tap ptr.
    - At c==32 the popped word leaves tap 31 and the push is accepted (no OVERFLOW).
  - WRITE and READ, c==0: push accepted, COUNT=1, read ignored, UNDERFLOW=1.
  - Neither: hold.
- Flags:
  - DATA_PRESENT, HALF_FULL and FULL are registered, decoded from the next COUNT, so they are valid in the same cycle as COUNT.
  - OVERFLOW and UNDERFLOW are registered single-cycle pulses and are not sticky.
- Ordering: strict first in, first out; no word is duplicated or reordered under any strobe combination.
- Arithmetic:
  - COUNT is 6 bits and saturates by rule, never wrapping.
  - ptr is derived combinationally and is always within 0..31.

Test Plan:
- Reset then idle -> COUNT=0, DATA_PRESENT=0, FULL=0, no pulses. Assert RESET_N low mid-cycle -> outputs clear without a clock edge.
- Push 0x11,0x22,0x33, then pop 3 -> DATA_OUT sequence 0x11,0x22,0x33; COUNT 3,2,1,0; DATA_PRESENT drops after the third pop.
- Push 0x00..0x1F (32 words) -> FULL=1, COUNT=32, HALF_FULL rose when COUNT reached 16. Push 0xAA -> OVERFLOW pulse, COUNT=32, DATA_OUT=0x00.
- When full, WRITE+READ with 0xBB for 1 cycle -> COUNT=32, no OVERFLOW, DATA_OUT=0x01. After 31 further pops DATA_OUT=0xBB.
- When empty, WRITE+READ 0x5A -> UNDERFLOW pulse, COUNT=1, DATA_OUT=0x5A. READ only when empty -> UNDERFLOW pulse, COUNT=0.
- Random WRITE/READ for 10k cycles against a queue model -> every popped DATA_OUT matches; COUNT and flags match the model each cycle.

Source files
------------

// File: rtl/srl_fifo_reader.sv
// Read end of a 32-deep shift-register FIFO. It holds the occupancy count,
// addresses the oldest tap, and produces the status flags and the error pulses.
module srl_fifo_reader #(
  parameter int WIDTH      = 8,
  parameter int HALF_LEVEL = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             WRITE,
  input  logic             READ,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_PRESENT,
  output logic             HALF_FULL,
  output logic             FULL,
  output logic [5:0]       COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [5:0] r_count;
  logic       r_present;
  logic       r_half;
  logic       r_full;
  logic       r_ovf;
  logic       r_unf;

  logic [5:0] w_count_next;
  logic       w_push;
  logic       w_ovf;
  logic       w_unf;
  logic [4:0] w_ptr;

  // A simultaneous pop at full frees tap 31 in the same edge, so the push is taken.
  always_comb begin
    w_count_next = r_count;
    w_push       = 1'b0;
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    case ({WRITE, READ})
      2'b10: begin
        if (r_count == 6'd32) begin
          w_ovf = 1'b1;
        end else begin
          w_push       = 1'b1;
          w_count_next = r_count + 6'd1;
        end
      end
      2'b01: begin
        if (r_count == 6'd0) begin
          w_unf = 1'b1;
        end else begin
          w_count_next = r_count - 6'd1;
        end
      end
      2'b11: begin
        w_push = 1'b1;
        if (r_count == 6'd0) begin
          w_unf        = 1'b1;
          w_count_next = 6'd1;
        end
      end
      default: ;
    endcase
  end

  // Count 32 has low bits 0, so the 5-bit decrement lands on 31 as required.
  assign w_ptr = (r_count == 6'd0) ? 5'd0 : (r_count[4:0] - 5'd1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count   <= 6'd0;
      r_present <= 1'b0;
      r_half    <= 1'b0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_present <= (w_count_next != 6'd0);
      r_half    <= (w_count_next >= 6'(HALF_LEVEL));
      r_full    <= (w_count_next == 6'd32);
      r_ovf     <= w_ovf;
      r_unf     <= w_unf;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_col
      logic [31:0] r_col = '0;

      always_ff @(posedge CLK) begin
        if (w_push) begin
          r_col <= {r_col[30:0], DATA_IN[gi]};
        end
      end

      assign DATA_OUT[gi] = r_col[w_ptr];
    end
  endgenerate

  assign COUNT        = r_count;
  assign DATA_PRESENT = r_present;
  assign HALF_FULL    = r_half;
  assign FULL         = r_full;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_unf;

endmodule

// File: tb/tb_srl_fifo_reader.sv
// Scoreboard bench for srl_fifo_reader: a queue model predicts data, count,
// flags and pulses; directed cases first, then a long random strobe run.
module tb_srl_fifo_reader;

  localparam int WIDTH      = 8;
  localparam int HALF_LEVEL = 16;

  logic             CLK;
  logic             RESET_N;
  logic [WIDTH-1:0] DATA_IN;
  logic             WRITE;
  logic             READ;
  logic [WIDTH-1:0] DATA_OUT;
  logic             DATA_PRESENT;
  logic             HALF_FULL;
  logic             FULL;
  logic [5:0]       COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb[$];

  srl_fifo_reader #(.WIDTH(WIDTH), .HALF_LEVEL(HALF_LEVEL)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .WRITE(WRITE), .READ(READ),
    .DATA_OUT(DATA_OUT), .DATA_PRESENT(DATA_PRESENT), .HALF_FULL(HALF_FULL),
    .FULL(FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_status(input logic exp_ovf, input logic exp_unf);
    int c;
    c = sb.size();
    check("count", 32'(COUNT), 32'(c));
    check("present", 32'(DATA_PRESENT), 32'(c > 0));
    check("half", 32'(HALF_FULL), 32'(c >= HALF_LEVEL));
    check("full", 32'(FULL), 32'(c == 32));
    check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
    check("underflow", 32'(UNDERFLOW), 32'(exp_unf));
    if (c > 0) check("head", 32'(DATA_OUT), 32'(sb[0]));
  endtask

  // Called at posedge+1; drives one cycle of strobes and checks the result.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    int   c;
    logic ovf;
    logic unf;
    WRITE   = w;
    READ    = r;
    DATA_IN = d;
    c   = sb.size();
    ovf = 1'b0;
    unf = 1'b0;
    if (r && c > 0) check("pop_data", 32'(DATA_OUT), 32'(sb[0]));
    if (w && r) begin
      if (c == 0) begin
        unf = 1'b1;
      end else begin
        void'(sb.pop_front());
      end
      sb.push_back(d);
    end else if (w) begin
      if (c < 32) sb.push_back(d);
      else ovf = 1'b1;
    end else if (r) begin
      if (c > 0) void'(sb.pop_front());
      else unf = 1'b1;
    end
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
    READ  = 1'b0;
    $display("step w=%0b r=%0b d=%02h count=%0d out=%02h ovf=%0b unf=%0b",
             w, r, d, COUNT, DATA_OUT, OVERFLOW, UNDERFLOW);
    check_status(ovf, unf);
  endtask

  initial begin
    int wthr;
    int rthr;
    RESET_N = 1'b0;
    WRITE   = 1'b0;
    READ    = 1'b0;
    DATA_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    check_status(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'h00);

    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check("abs_count3", 32'(COUNT), 32'd3);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    check("abs_empty", 32'(DATA_PRESENT), 32'd0);

    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 8'(i));
    check("abs_full", 32'(FULL), 32'd1);
    step(1'b1, 1'b0, 8'hAA);
    check("abs_ovf_out", 32'(DATA_OUT), 32'h00);
    step(1'b1, 1'b1, 8'hBB);
    check("abs_wr_full", 32'(DATA_OUT), 32'h01);
    repeat (31) step(1'b0, 1'b1, 8'h00);
    check("abs_last", 32'(DATA_OUT), 32'hBB);
    step(1'b0, 1'b1, 8'h00);

    step(1'b1, 1'b1, 8'h5A);
    check("abs_wr_empty", 32'(DATA_OUT), 32'h5A);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);

    // Asynchronous reset in mid-cycle, while an UNDERFLOW pulse is showing.
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    #2;
    RESET_N = 1'b0;
    #1;
    sb.delete();
    check_status(1'b0, 1'b0);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check_status(1'b0, 1'b0);

    for (int ph = 0; ph < 4; ph++) begin
      wthr = (ph == 0) ? 3 : (ph == 1) ? 1 : 2;
      rthr = (ph == 0) ? 1 : (ph == 1) ? 3 : 2;
      for (int i = 0; i < 2500; i++) begin
        step(($urandom_range(0, 3) < wthr), ($urandom_range(0, 3) < rthr),
             8'($urandom_range(0, 255)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
